// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the MEM stage and a
// word-addressed data memory. Loads are combinational with sign/zero
// extension; word stores commit in the request cycle; byte and halfword
// stores are a registered read-modify-write that stalls for one cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accept requests; loads, word stores and faults resolve here
// MERGE | write back old_word with the captured lane replaced
module mem_access_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req_Valid,
  input  logic             Req_Write,
  input  logic [1:0]       Req_Size,
  input  logic             Req_Unsigned,
  input  logic [WIDTH-1:0] Req_Addr,
  input  logic [WIDTH-1:0] Req_WData,
  input  logic [WIDTH-1:0] Mem_RD,
  output logic [WIDTH-1:0] Mem_A,
  output logic [WIDTH-1:0] Mem_WD,
  output logic             Mem_WE,
  output logic [WIDTH-1:0] Load_Data,
  output logic             Stall,
  output logic             Misaligned
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] old_word_q, old_word_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       size_q, size_d;

  logic             req_misaligned;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_ext;
  logic [WIDTH-1:0] merge_word;

  // Alignment fault detection for the current request
  always_comb begin
    req_misaligned = 1'b0;
    case (Req_Size)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = Req_Addr[0];
      SZ_WORD: req_misaligned = (Req_Addr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  // Lane select and sign/zero extension of the memory read word
  always_comb begin
    ld_byte = 8'h00;
    case (Req_Addr[1:0])
      2'd0:    ld_byte = Mem_RD[7:0];
      2'd1:    ld_byte = Mem_RD[15:8];
      2'd2:    ld_byte = Mem_RD[23:16];
      default: ld_byte = Mem_RD[31:24];
    endcase
    ld_half = Req_Addr[1] ? Mem_RD[31:16] : Mem_RD[15:0];
    ld_ext  = Mem_RD;
    if (Req_Size == SZ_BYTE) begin
      ld_ext = {{24{ld_byte[7] & ~Req_Unsigned}}, ld_byte};
    end else if (Req_Size == SZ_HALF) begin
      ld_ext = {{16{ld_half[15] & ~Req_Unsigned}}, ld_half};
    end
  end

  // Replace the captured lane of the old word with the captured store data
  always_comb begin
    merge_word = old_word_q;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merge_word[7:0]   = data_q[7:0];
        2'd1:    merge_word[15:8]  = data_q[7:0];
        2'd2:    merge_word[23:16] = data_q[7:0];
        default: merge_word[31:24] = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = data_q;
    end else begin
      merge_word[15:0] = data_q;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    old_word_d = old_word_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    Mem_A      = {2'b00, Req_Addr[WIDTH-1:2]};
    Mem_WD     = '0;
    Mem_WE     = 1'b0;
    Load_Data  = '0;
    Stall      = 1'b0;
    Misaligned = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          if (req_misaligned) begin
            Misaligned = 1'b1;
          end else if (!Req_Write) begin
            Load_Data = ld_ext;
          end else if (Req_Size == SZ_WORD) begin
            Mem_WD = Req_WData;
            Mem_WE = 1'b1;
          end else begin
            Stall      = 1'b1;
            old_word_d = Mem_RD;
            addr_d     = Req_Addr;
            data_d     = Req_WData[15:0];
            size_d     = Req_Size;
            state_d    = MERGE;
          end
        end
      end
      MERGE: begin
        Mem_A   = {2'b00, addr_q[WIDTH-1:2]};
        Mem_WD  = merge_word;
        Mem_WE  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every side effect, including a pending merge write
    if (RST) begin
      Mem_WD     = '0;
      Mem_WE     = 1'b0;
      Load_Data  = '0;
      Stall      = 1'b0;
      Misaligned = 1'b0;
    end
  end

  // State and read-modify-write capture registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      old_word_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      old_word_q <= old_word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Req_Valid;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Unsigned;
  logic [31:0] Req_Addr;
  logic [31:0] Req_WData;
  logic [31:0] Mem_RD;
  logic [31:0] Mem_A;
  logic [31:0] Mem_WD;
  logic        Mem_WE;
  logic [31:0] Load_Data;
  logic        Stall;
  logic        Misaligned;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  mem_access_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .Req_Valid(Req_Valid), .Req_Write(Req_Write), .Req_Size(Req_Size),
    .Req_Unsigned(Req_Unsigned), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
    .Mem_RD(Mem_RD), .Mem_A(Mem_A), .Mem_WD(Mem_WD), .Mem_WE(Mem_WE),
    .Load_Data(Load_Data), .Stall(Stall), .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  assign Mem_RD = mem[Mem_A[5:0]];

  always @(posedge CLK) begin
    if (Mem_WE) mem[Mem_A[5:0]] <= Mem_WD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd);
    Req_Valid    = v;
    Req_Write    = w;
    Req_Size     = sz;
    Req_Unsigned = u;
    Req_Addr     = a;
    Req_WData    = wd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // Sub-word store: checks the stall cycle, then the merge cycle with junk inputs
  task automatic sub_store(input string tag, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_a, input logic [31:0] exp_wd);
    req(1'b1, 1'b1, sz, 1'b0, a, wd);
    mid();
    check({tag, " c1 stall"}, {31'b0, Stall}, 32'd1);
    check({tag, " c1 we"}, {31'b0, Mem_WE}, 32'd0);
    step();
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_007C, 32'h0);
    mid();
    check({tag, " c2 we"}, {31'b0, Mem_WE}, 32'd1);
    check({tag, " c2 wd"}, Mem_WD, exp_wd);
    check({tag, " c2 addr"}, Mem_A, exp_a);
    check({tag, " c2 stall"}, {31'b0, Stall}, 32'd0);
    check({tag, " c2 ld"}, Load_Data, 32'd0);
    step();
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
    req(1'b1, 1'b0, sz, u, a, 32'h0);
    mid();
    check({tag, " data"}, Load_Data, exp);
    check({tag, " stall"}, {31'b0, Stall}, 32'd0);
    step();
  endtask

  task automatic bad(input string tag, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    req(1'b1, w, sz, 1'b0, a, wd);
    mid();
    check({tag, " mis"}, {31'b0, Misaligned}, 32'd1);
    check({tag, " we"}, {31'b0, Mem_WE}, 32'd0);
    check({tag, " stall"}, {31'b0, Stall}, 32'd0);
    check({tag, " ld"}, Load_Data, 32'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    #0;
    mem[1]  <= 32'hCAFE_F00D;
    mem[8]  <= 32'h80FF_7F01;
    mem[16] <= 32'h1234_5678;

    // Reset with an active word store presented: nothing may leak out
    RST = 1'b1;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF);
    mid();
    check("rst we", {31'b0, Mem_WE}, 32'd0);
    check("rst stall", {31'b0, Stall}, 32'd0);
    check("rst mis", {31'b0, Misaligned}, 32'd0);
    check("rst wd", Mem_WD, 32'd0);
    step();
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    mid();
    check("rst ld", Load_Data, 32'd0);
    step();
    RST = 1'b0;
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    mid();
    check("idle we", {31'b0, Mem_WE}, 32'd0);
    check("idle ld", Load_Data, 32'd0);
    step();

    // Word store then word load
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344);
    mid();
    check("sw addr", Mem_A, 32'd4);
    check("sw we", {31'b0, Mem_WE}, 32'd1);
    check("sw wd", Mem_WD, 32'h1122_3344);
    check("sw stall", {31'b0, Stall}, 32'd0);
    step();
    load("lw 0x10", 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344);

    // Sub-word read-modify-write
    sub_store("sb 0x11", 2'b00, 32'h0000_0011, 32'hFFFF_FFAB, 32'd4, 32'h1122_AB44);
    sub_store("sh 0x12", 2'b01, 32'h0000_0012, 32'h0000_BEEF, 32'd4, 32'hBEEF_AB44);
    load("lw after sh", 2'b10, 1'b0, 32'h0000_0010, 32'hBEEF_AB44);

    // Load extension on 0x80FF7F01
    load("lb 0x23", 2'b00, 1'b0, 32'h0000_0023, 32'hFFFF_FF80);
    load("lbu 0x23", 2'b00, 1'b1, 32'h0000_0023, 32'h0000_0080);
    load("lh 0x22", 2'b01, 1'b0, 32'h0000_0022, 32'hFFFF_80FF);
    load("lhu 0x22", 2'b01, 1'b1, 32'h0000_0022, 32'h0000_80FF);
    load("lb 0x21", 2'b00, 1'b0, 32'h0000_0021, 32'h0000_007F);
    load("lbu 0x20", 2'b00, 1'b1, 32'h0000_0020, 32'h0000_0001);
    load("lh 0x20", 2'b01, 1'b0, 32'h0000_0020, 32'h0000_7F01);
    load("lw u 0x20", 2'b10, 1'b1, 32'h0000_0020, 32'h80FF_7F01);

    // Misaligned requests
    bad("sw 0x06", 1'b1, 2'b10, 32'h0000_0006, 32'hDEAD_BEEF);
    bad("lh 0x05", 1'b0, 2'b01, 32'h0000_0005, 32'h0);
    bad("sz11 st", 1'b1, 2'b11, 32'h0000_0010, 32'h0BAD_0BAD);
    bad("sh 0x13", 1'b1, 2'b01, 32'h0000_0013, 32'h0000_1234);
    load("lw 0x04 kept", 2'b10, 1'b0, 32'h0000_0004, 32'hCAFE_F00D);
    load("lw 0x10 kept", 2'b10, 1'b0, 32'h0000_0010, 32'hBEEF_AB44);

    // Back-to-back byte stores into the same word
    sub_store("b2b sb 0x30", 2'b00, 32'h0000_0030, 32'h0000_0011, 32'd12, 32'h0000_0011);
    sub_store("b2b sb 0x31", 2'b00, 32'h0000_0031, 32'h0000_0022, 32'd12, 32'h0000_2211);
    load("lw 0x30", 2'b10, 1'b0, 32'h0000_0030, 32'h0000_2211);

    // Reset asserted in the MERGE cycle drops the write
    req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'h0000_00FF);
    mid();
    check("rm c1 stall", {31'b0, Stall}, 32'd1);
    step();
    RST = 1'b1;
    mid();
    check("rm we", {31'b0, Mem_WE}, 32'd0);
    check("rm wd", Mem_WD, 32'd0);
    check("rm stall", {31'b0, Stall}, 32'd0);
    step();
    RST = 1'b0;
    load("rm lw 0x40", 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0);
    mid();
    check("rm idle we", {31'b0, Mem_WE}, 32'd0);
    check("rm lbu 0x41", Load_Data, 32'h0000_0056);
    step();
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the MEM pipeline stage and the word-addressed data memory. It converts byte addresses to word indices and handles byte, halfword and word accesses with sign or zero extension. Sub-word stores are done as a registered read-modify-write that stalls the pipeline for one cycle. Misaligned requests are flagged and suppressed.

## Interface
- WIDTH, 32: data and address width. Only 32 is supported.
- CLK  in  1  clock. Memory writes on the same rising edge.
- RST  in  1  reset. Synchronous and active-high.
- Req_Valid  in  1  MEM-stage access request.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Size  in  2  Access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- Req_Unsigned  in  1  Zero-extend sub-word loads. Ignored for stores and for word loads.
- Req_Addr  in  WIDTH  Byte address.
- Req_WData  in  WIDTH  Store data. Sub-word data is taken from the low bits.
- Mem_RD  in  WIDTH  Combinational read data from memory.
- Mem_A  out  WIDTH  Word index sent to memory.
- Mem_WD  out  WIDTH  Write data sent to memory.
- Mem_WE  out  1  Memory write enable.
- Load_Data  out  WIDTH  Extended load result. Combinational.
- Stall  out  1  Freeze the pipeline this cycle.
- Misaligned  out  1  Access fault this cycle.

## Operation
- **Byte lanes (little-endian).** Byte k = bits [8k+7:8k], where k = Req_Addr[1:0]. Halfword lane = Req_Addr[1].
- **Fault condition.** A request is misaligned if any of these hold:
  - Size 11.
  - Halfword with Addr[0]=1.
  - Word with Addr[1:0]≠00.
- **Fault response.** When Req_Valid=1 and the request is misaligned:
  - Misaligned=1.
  - Mem_WE=0.
  - Load_Data=0.
  - Stall=0.
  - FSM stays in IDLE.
- **FSM states:** IDLE and MERGE.
- **In IDLE** (Mem_A = {2'b00, Req_Addr[31:2]}):
  - No request: Mem_WE=0, Stall=0, Load_Data=0.
  - Load: Load_Data is the selected lane from Mem_RD. It is sign-extended, or zero-extended if Req_Unsigned=1. A word load passes through unchanged. No stall.
  - Word store: Mem_WD=Req_WData and Mem_WE=1 in the same cycle. No stall.
  - Byte or halfword store:
    - Mem_WE=0 and Stall=1.
    - Capture Mem_RD into old_word, Req_Addr into addr_q, Req_WData into data_q, and Req_Size into size_q.
    - Next state is MERGE.
- **In MERGE:**
  - Mem_A = addr_q[31:2].
  - Mem_WD = old_word with the addressed lane replaced by data_q[7:0] or data_q[15:0]. Other lanes are unchanged.
  - Mem_WE=1, Stall=0, Misaligned=0, Load_Data=0.
  - Request inputs are ignored in this cycle. Next state is always IDLE.
- **Pipeline contract.** The pipeline holds the request stable while Stall=1. The instruction completes in the MERGE cycle and the next request is presented in the following cycle.
- **Back-to-back sub-word stores to the same word.** The second store's read returns the first store's merged result, because memory is written on the edge between the two accesses.

## Timing
- **Reset.** With RST=1 at a clock edge:
  - State becomes IDLE.
  - old_word, addr_q, data_q and size_q clear to 0.
  - While RST is high: Stall=0, Mem_WE=0, Misaligned=0, Load_Data=0, Mem_WD=0.
- **Reset during MERGE.** The pending write is dropped (Mem_WE forced to 0) and the state returns to IDLE.
- **Latency.**
  - Load: 0 cycles. Result is valid in the request cycle.
  - Word store: commits at the end of the request cycle.
  - Sub-word store: 2 cycles. Stall=1 in cycle 1; the write commits at the end of cycle 2.
- **Combinational outputs.** Stall, Misaligned and Load_Data depend only on the current state, inputs and Mem_RD. Mem_WE and Mem_WD in MERGE depend only on registers.

## Test plan
- **Word store then word load.** sw 0x11223344 to addr 0x10, then lw addr 0x10. Expect Mem_A=4 and Mem_WE=1 for one cycle, then Load_Data=0x11223344 with no stall.
- **Sub-word store read-modify-write.**
  - Stimulus: with word 4 = 0x11223344, sb 0xAB to addr 0x11.
  - Cycle 1: Stall=1, Mem_WE=0.
  - Cycle 2: Mem_WD=0x1122AB44, Mem_WE=1.
  - Then sh 0xBEEF to addr 0x12: word becomes 0xBEEFAB44.
- **Load extension** with word 0x80FF7F01 at addr 0x20:
  - lb addr 0x23 → 0xFFFFFF80.
  - lbu addr 0x23 → 0x00000080.
  - lh addr 0x22 → 0xFFFF80FF.
  - lhu addr 0x22 → 0x000080FF.
  - lb addr 0x21 → 0x0000007F.
- **Misaligned requests.**
  - sw to addr 0x06, lh to addr 0x05, and size 11: each gives Misaligned=1, Mem_WE=0, Stall=0.
  - Memory contents are unchanged afterwards.
- **Back-to-back sub-word stores.** With word 0x00000000, sb 0x11 to addr 0x30, then sb 0x22 to addr 0x31. Final word = 0x00002211, with two stall cycles in total.
- **Reset during MERGE.** Assert RST in the MERGE cycle of sb 0xFF to addr 0x40. Expect no write and word unchanged. After release: Stall=0 and the state is IDLE.
